// File: rtl/dm_store_unit.sv
// M-stage data memory: lane-aligned masked word stores, combinational extended loads and a committed-store counter.
// Optional macro DM_WRITE_TRACE_EN prints one trace line per committed store.
module dm_store_unit #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byteen,
  input  logic [2:0]       dmr_op,
  output logic [31:0]      rdata,
  output logic             st_err,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;
  logic [31:0]      wr_word_d;

  logic [31:0]      offset;
  logic [IDX_W-1:0] wordIdx;
  logic             inRange;
  logic [31:0]      memWord;
  logic             legal;
  logic [31:0]      aligned;
  logic             commit;
  logic [31:0]      byteShift;
  logic [7:0]       byteSel;
  logic [15:0]      halfSel;

  assign offset  = addr - ADDR_BASE;
  assign wordIdx = offset[IDX_W+1:2];
  assign inRange = (addr >= ADDR_BASE) && ({2'b00, offset[31:2]} < DEPTH_WORDS);
  assign memWord = inRange ? mem_q[wordIdx] : 32'h0;

  // The byteen pattern alone decides both legality and how rt is replicated across lanes.
  always_comb begin
    legal   = 1'b0;
    aligned = wdata;
    case (byteen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        legal   = 1'b1;
        aligned = {4{wdata[7:0]}};
      end
      4'b0011, 4'b1100: begin
        legal   = 1'b1;
        aligned = {2{wdata[15:0]}};
      end
      4'b1111: begin
        legal   = 1'b1;
        aligned = wdata;
      end
      default: begin
        legal   = 1'b0;
        aligned = wdata;
      end
    endcase
  end

  assign st_err = (byteen != 4'b0000) && (!legal || !inRange);
  assign commit = (byteen != 4'b0000) && legal && inRange && !reset;

  always_comb begin
    wr_word_d = memWord;
    for (int k = 0; k < 4; k++) begin
      if (byteen[k]) wr_word_d[8*k +: 8] = aligned[8*k +: 8];
    end
  end

  assign wr_cnt_d = wr_cnt_q + CNT_W'(1);

  // Reset clears every word in one edge and overrides any store presented alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'h0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      mem_q[wordIdx] <= wr_word_d;
      wr_cnt_q       <= wr_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;

  assign byteShift = memWord >> {addr[1:0], 3'b000};
  assign byteSel   = byteShift[7:0];
  assign halfSel   = addr[1] ? memWord[31:16] : memWord[15:0];

  always_comb begin
    case (dmr_op)
      3'd1:    rdata = {{24{byteSel[7]}}, byteSel};
      3'd2:    rdata = {24'h0, byteSel};
      3'd3:    rdata = {{16{halfSel[15]}}, halfSel};
      3'd4:    rdata = {16'h0, halfSel};
      default: rdata = memWord;
    endcase
  end

`ifdef DM_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (commit) $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, wr_word_d);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule
